// File: rtl/truth_table_sequencer.sv
// Drives every input combination into a combinational block, samples its
// output after a settle window and grades the observed truth table.
module truth_table_sequencer #(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  input  logic                   dut_x,
  output logic [N_IN-1:0]        abc,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   result,
  output logic                   pass,
  output logic [N_IN:0]          err_count
);

  localparam int unsigned NV = 1 << N_IN;
  localparam logic [N_IN-1:0] IDX_MAX  = N_IN'(NV - 1);
  localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);
  localparam logic [7:0]      CNT_LAST = 8'(SETTLE - 1);
  localparam logic [N_IN:0]   ERR_ZERO = '0;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_IN-1:0] abc_q, abc_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [NV-1:0]   exp_q, exp_d;
  logic [NV-1:0]   result_q, result_d;
  logic [N_IN:0]   err_q, err_d;
  logic            busy_q, busy_d;
  logic            pass_q, pass_d;
  logic            miss;

  assign miss = dut_x ^ exp_q[idx_q];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    abc_d    = abc_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    result_d = result_q;
    err_d    = err_q;
    busy_d   = busy_q;
    pass_d   = pass_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start) begin
          exp_d    = expected;
          idx_d    = '0;
          abc_d    = '0;
          cnt_d    = '0;
          result_d = '0;
          err_d    = '0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_SETTLE;
        end
      end
      (state_q == S_SETTLE): begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == CNT_LAST) state_d = S_SAMPLE;
      end
      (state_q == S_SAMPLE): begin
        result_d[idx_q] = dut_x;
        err_d = err_q + {{N_IN{1'b0}}, miss};
        if (idx_q == IDX_MAX) begin
          // grade early so pass is already valid while done is high
          pass_d  = (err_d == ERR_ZERO);
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          abc_d   = idx_q + IDX_ONE;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        pass_d  = (err_q == ERR_ZERO);
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      abc_q    <= '0;
      cnt_q    <= '0;
      exp_q    <= '0;
      result_q <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      abc_q    <= abc_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      pass_q   <= pass_d;
    end
  end

  assign abc       = abc_q;
  assign busy      = busy_q;
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule
